// File: rtl/pipe_reg_skid_if.sv
// Valid/ready handshake bundle for pipe_reg_skid.
// The stage attaches through the slave modport. The driving environment attaches
// through the master modport: producer inputs, consumer ready, and the stage observed.
interface pipe_reg_skid_if #(
    parameter int WID_DATA = 32
);
    logic                InValid;
    logic                InReady;
    logic [WID_DATA-1:0] DataIn;
    logic                OutValid;
    logic                OutReady;
    logic [WID_DATA-1:0] DataOut;
    logic [1:0]          Count;

    modport slave (
        input  InValid,
        input  DataIn,
        input  OutReady,
        output InReady,
        output OutValid,
        output DataOut,
        output Count
    );

    modport master (
        output InValid,
        output DataIn,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  DataOut,
        input  Count
    );
endinterface

// File: rtl/pipe_reg_skid.sv
// Two-entry valid/ready pipeline register, built from a main register and a skid register.
// The stage accepts one word per cycle under back-pressure. InReady is decoded
// from the registered entry count, so it has no combinational path from OutReady.
// Optional synchronous flush: define PIPE_REG_SKID_FLUSH_EN to enable the Flush port.
module pipe_reg_skid #(
    parameter int                  WID_DATA   = 32,
    parameter logic [WID_DATA-1:0] RESET_DATA = '0
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Flush,
    pipe_reg_skid_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WID_DATA-1:0] main_q, main_d;
    logic [WID_DATA-1:0] skid_q, skid_d;
    logic                accept;
    logic                fire;
    logic                flush_req;

`ifdef PIPE_REG_SKID_FLUSH_EN
    assign flush_req = Flush;
`else
    // Flush is kept on the port list so both builds share one pinout.
    logic unused_flush;
    assign unused_flush = Flush;
    assign flush_req    = 1'b0;
`endif

    // Handshake outputs are decoded only from the count. Reset holds them low.
    assign bus.InReady  = ResetN && (state_q != ST_FULL);
    assign bus.OutValid = ResetN && (state_q != ST_EMPTY);
    assign bus.DataOut  = main_q;
    assign bus.Count    = state_q;

    assign accept = bus.InValid  && bus.InReady;
    assign fire   = bus.OutValid && bus.OutReady;

    // Next-state and data-steering decode for the three occupancy states.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = bus.DataIn;
                end
            end
            ST_ONE: begin
                if (accept && fire) begin
                    main_d = bus.DataIn;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = bus.DataIn;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and data registers. Reset has priority over flush, and flush has priority over transfers.
    always_ff @(posedge Clock) begin
        // NOTE: use non-blocking assignments for sequential state, so every register samples pre-edge values.
        if (!ResetN || flush_req) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid.
// A queue-based reference model tracks the entries held by the stage. The bench
// runs directed scenarios and then random traffic, and checks the DUT against the model.
// Defining PIPE_REG_SKID_FLUSH_EN switches the model's flush expectation.
module tb_pipe_reg_skid;
    localparam int          W   = 32;
    localparam logic [W-1:0] RST = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] last_main;

    pipe_reg_skid_if #(.WID_DATA(W)) bus ();

    pipe_reg_skid #(.WID_DATA(W), .RESET_DATA(RST)) dut (
        .Clock (clk),
        .ResetN(rst_n),
        .Flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus. Check the handshake before the edge and the state after it.
    task automatic step(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                        input logic ordy);
        bit acc, fir, fl;
        rst_n             = r;
        flush             = f;
        bus.InValid       = iv;
        bus.DataIn        = d;
        bus.OutReady      = ordy;
        #1;
        check("in_ready",  {31'd0, bus.InReady},  {31'd0, (r && model_q.size() < 2)});
        check("out_valid", {31'd0, bus.OutValid}, {31'd0, (r && model_q.size() > 0)});
        acc = r && iv && (model_q.size() < 2);
        fir = r && ordy && (model_q.size() > 0);
`ifdef PIPE_REG_SKID_FLUSH_EN
        fl = f;
`else
        fl = 1'b0;
`endif
        @(posedge clk);
        if (!r || fl) begin
            model_q.delete();
            last_main = RST;
        end else begin
            if (fir) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
            if (model_q.size() > 0) last_main = model_q[0];
        end
        #1;
        check("count",    {30'd0, bus.Count}, model_q.size());
        check("data_out", bus.DataOut, last_main);
    endtask

    initial begin
        last_main = RST;
        // Reset with a transfer offered; it must not be accepted.
        step(0, 0, 1, 32'hDEAD_BEEF, 1);
        step(0, 0, 1, 32'hDEAD_BEEF, 1);
        check("rst_count", {30'd0, bus.Count}, 32'd0);
        check("rst_data",  bus.DataOut, RST);
        step(1, 0, 0, 0, 0);
        check("rst_ready", {31'd0, bus.InReady}, 32'd1);

        // Streaming at one word per cycle.
        step(1, 0, 1, 32'h1, 1);
        step(1, 0, 1, 32'h2, 1);
        check("stream_cnt", {30'd0, bus.Count}, 32'd1);
        step(1, 0, 1, 32'h3, 1);
        check("stream_d3", bus.DataOut, 32'h3);
        step(1, 0, 0, 0, 1);

        // Back-pressure fills the skid register.
        step(1, 0, 1, 32'hA, 0);
        step(1, 0, 1, 32'hB, 0);
        check("bp_count", {30'd0, bus.Count}, 32'd2);
        check("bp_data",  bus.DataOut, 32'hA);
        step(1, 0, 1, 32'hC, 1);
        check("bp_pop_b", bus.DataOut, 32'hB);
        step(1, 0, 0, 0, 1);

        // ONE holding 0x5 with a simultaneous accept and fire.
        step(1, 0, 1, 32'h5, 0);
        step(1, 0, 1, 32'h6, 1);
        check("af_data",  bus.DataOut, 32'h6);
        check("af_count", {30'd0, bus.Count}, 32'd1);
        step(1, 0, 0, 0, 1);

        // Flush while FULL with the consumer ready.
        step(1, 0, 1, 32'h7, 0);
        step(1, 0, 1, 32'h8, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Mid-operation reset while FULL.
        step(1, 0, 1, 32'h11, 0);
        step(1, 0, 1, 32'h12, 0);
        step(0, 0, 0, 0, 1);
        check("mid_rst_count", {30'd0, bus.Count}, 32'd0);
        step(1, 0, 0, 0, 1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised pipeline register for the Kabeta datapath. It replaces a plain enable-gated register with a two-entry valid/ready stage: a main register plus a skid register. The stage sustains one transfer per cycle under back-pressure, has no combinational path from `OutReady` to `InReady`, and supports optional synchronous flush. It sits between pipeline stages and wherever a producer and a consumer stall independently.

## Interface
- `WID_DATA`, default 32: data width in bits (≥1).
- `RESET_DATA`, default 0: value loaded into both data registers on reset and on flush; `WID_DATA` bits wide.

- `Clock`  in  1: single clock; all state updates on its rising edge.
- `ResetN`  in  1: reset, synchronous and active-low.
- `Flush`  in  1: synchronous discard of both entries. Effective only when `PIPE_REG_SKID_FLUSH_EN` is defined.
- `InValid`  in  1: producer presents `DataIn`.
- `InReady`  out  1: stage can accept; driven only from registered state.
- `DataIn`  in  `WID_DATA`: input data.
- `OutValid`  out  1: `DataOut` holds a valid entry.
- `OutReady`  in  1: consumer accepts `DataOut`.
- `DataOut`  out  `WID_DATA`: main register contents.
- `Count`  out  2: number of entries held (0, 1 or 2).

## Operation
- Accept is `InValid & InReady`. Fire is `OutValid & OutReady`.
- State register `Count` has three states: EMPTY (0), ONE (1), FULL (2).
- Outputs: `OutValid = (Count != 0)`, `InReady = (Count != 2)`. Both are forced to 0 while `ResetN` is low.
- EMPTY:
  - accept → ONE, main ← `DataIn`.
  - otherwise stay in EMPTY.
- ONE:
  - accept & fire → ONE, main ← `DataIn`.
  - accept & !fire → FULL, skid ← `DataIn`.
  - fire & !accept → EMPTY.
  - neither → hold.
- FULL:
  - fire → ONE, main ← skid. Accept cannot occur because `InReady` is 0.
  - no fire → hold.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- `DataOut` is stable while `OutValid & !OutReady`.
- `DataIn` is ignored whenever accept is false.
- Priority within a single edge: `ResetN` low > `Flush` > accept/fire.
- Reset (`ResetN` low at an edge): `Count` ← 0, main ← `RESET_DATA`, skid ← `RESET_DATA`. Any in-flight entries are lost. A transfer offered on the reset edge is not accepted.
- Flush (macro defined, `ResetN` high): same effect as reset. An accept or fire offered on the flush edge is void, because the producer and consumer both see `InReady`/`OutValid` but the data is discarded. Producers and consumers must treat a flush cycle as a cancellation.

## Timing
- Latency: 1 cycle from an accept edge to `OutValid` when the stage was EMPTY. In ONE with a simultaneous fire, the new word appears on `DataOut` the next cycle.
- Throughput: 1 word/cycle in steady state with `OutReady` held high.
- Back-pressure: after `OutReady` drops, `InReady` falls 1 cycle later, i.e. after the skid fills. Exactly one extra word is absorbed.
- Out of reset: `InReady` = 1 and `OutValid` = 0 in the first cycle with `ResetN` high. `DataOut` = `RESET_DATA`, `Count` = 0.
- All outputs are registered or decoded from `Count` only. There is no in→out combinational path on valid, ready or data.

## Configuration
- `PIPE_REG_SKID_FLUSH_EN` defined: `Flush` behaves as described in Operation.
- `PIPE_REG_SKID_FLUSH_EN` not defined: the `Flush` port still exists but is ignored, and no flush logic is synthesised. Only `ResetN` clears the stage.

## Test plan
- Reset: hold `ResetN`=0 for 2 cycles with `InValid`=1 and `DataIn`=0xDEADBEEF.
  - During reset: `InReady`=0, `OutValid`=0.
  - After release: `Count`=0, `DataOut`=`RESET_DATA`, and nothing is accepted.
- Streaming: drive 0x1, 0x2, 0x3 on consecutive cycles with `OutReady`=1. `DataOut` must show 0x1, 0x2, 0x3 one cycle later each, with `Count` staying at 1.
- Back-pressure: `OutReady`=0, push 0xA then 0xB.
  - Result: `Count`=2, `InReady`=0, `DataOut`=0xA.
  - Raise `OutReady`: 0xA then 0xB emerge, and `InReady` returns to 1 after the first fire.
- Simultaneous accept and fire in ONE, holding 0x5, while pushing 0x6: next cycle `DataOut`=0x6 and `Count`=1.
- Flush, macro defined: in FULL (0x7, 0x8), assert `Flush` together with `OutReady`=1.
  - Next cycle: `Count`=0, `OutValid`=0, `DataOut`=`RESET_DATA`.
  - Neither 0x7 nor 0x8 ever reappears.
  - With the macro undefined, the same stimulus delivers 0x7 and then 0x8.
- Mid-operation reset: in FULL, pull `ResetN` low for 1 cycle together with `Flush`=0 and `OutReady`=1. Afterwards `Count`=0 and both stored words are gone.
